gcd_driver: RTL
===============

// Module: gcd_driver
// PURPOSE
//  Initiator side of the gcd core's START/DONE protocol. Accepts operand pairs on a
//  valid/ready request port and drives A/B/START into one gcd core. Waits for DONE
//  with a timeout, then returns Y/ERROR on a valid/ready response port.
//  Sits between a system-side requester and the gcd datapath. Sole owner of the core's inputs.
// PARAMETERS
//  DW       8     operand/result width; must match the gcd core
//  TIMEOUT  1023  max WAIT cycles before abandoning an operation (>=1)
//  CNTW     16    width of the completed-operation counter
// PORTS
//  CLK          in   1     clock, all logic on rising edge
//  RST          in   1     synchronous, active-high reset
//  REQ_VALID    in   1     request operands valid
//  REQ_READY    out  1     driver can accept a request
//  REQ_A        in   DW    operand A
//  REQ_B        in   DW    operand B
//  RSP_VALID    out  1     response valid, held until RSP_READY
//  RSP_READY    in   1     consumer accepts response
//  RSP_Y        out  DW    gcd result (0 on error/timeout)
//  RSP_ERROR    out  1     zero operand (local check or core ERROR)
//  RSP_TIMEOUT  out  1     core did not assert DONE within TIMEOUT cycles
//  GCD_A        out  DW    to core A, held stable from ISSUE through WAIT
//  GCD_B        out  DW    to core B, held stable from ISSUE through WAIT
//  GCD_START    out  1     to core START, one-cycle pulse
//  GCD_Y        in   DW    from core Y
//  GCD_DONE     in   1     from core DONE, one-cycle pulse
//  GCD_ERROR    in   1     from core ERROR
//  BUSY         out  1     1 in any state other than IDLE
//  OP_COUNT     out  CNTW  responses handed off since reset, saturating
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including REQ_READY, GCD_A/B, OP_COUNT and timer.
//   REQ_READY rises on the first cycle after RST deasserts.
//  RST mid-operation aborts immediately. A later GCD_DONE from the abandoned op is ignored.
//  FSM (registered outputs):
//   IDLE:  REQ_READY=1. Handshake REQ_VALID&REQ_READY latches REQ_A/REQ_B.
//          If REQ_A==0 or REQ_B==0: go to RESP with Y=0, ERROR=1, TIMEOUT=0, and never pulse START.
//          Otherwise: GCD_A/B load the operands, go to ISSUE.
//   ISSUE: GCD_START=1 for exactly this cycle; timer cleared; go to WAIT.
//   WAIT:  timer +1 per cycle.
//          If GCD_DONE=1: capture GCD_Y and GCD_ERROR, TIMEOUT=0, go to RESP.
//           On GCD_ERROR=1, RSP_Y is forced to 0.
//          Else if timer==TIMEOUT-1: Y=0, ERROR=0, TIMEOUT=1, go to RESP.
//          DONE in the same cycle as expiry: DONE wins.
//   RESP:  RSP_VALID=1; RSP_Y/ERROR/TIMEOUT held stable.
//          On RSP_READY: OP_COUNT+1 (sticks at all-ones); go to IDLE.
//  REQ_READY=0 outside IDLE, so at most one operation is outstanding. No back-to-back bypass.
//  GCD_DONE outside WAIT is ignored, with no state change.
//  GCD_A/B keep their last value after the op. They change only on a new nonzero request.
//  Latency:
//   request accepted at cycle t -> GCD_START at t+1;
//   GCD_DONE at cycle d -> RSP_VALID at d+1;
//   zero-operand request accepted at t -> RSP_VALID at t+1.
//  Timer width: $clog2(TIMEOUT+1). Timeout fires exactly TIMEOUT cycles after entering WAIT.
// TESTING
//  1 REQ 48,18, model DONE Y=6 three cycles after START
//    -> START one pulse at t+1, GCD_A=48/B=18 held, RSP Y=6 ERR=0 TO=0, OP_COUNT=1
//  2 REQ 0,7 -> no GCD_START, RSP_VALID at t+1, Y=0 ERR=1 TO=0
//  3 TIMEOUT=16, core never DONE -> RSP_VALID 16 cycles after WAIT entry, Y=0 TO=1 ERR=0;
//    same run with DONE at the expiry cycle -> TO=0, Y=captured value
//  4 RSP_READY low 5 cycles -> RSP fields stable, REQ_READY=0, stray DONE ignored;
//    RSP_READY high -> IDLE next cycle
//  5 RST pulsed mid-WAIT -> all outputs 0 next cycle; subsequent GCD_DONE ignored; OP_COUNT=0
//  6 against the team gcd core: (255,85)->85, (13,7)->1, (9,9)->9, (0,0)->ERR=1;
//    OP_COUNT=4, no timeouts

Source files
------------

// File: rtl/gcd_driver_if.sv
// Request/response handshake bundle between a system-side requester and gcd_driver.
// The driver is the slave: it accepts requests and produces responses.
interface gcd_driver_if #(
    parameter int DW = 8
);
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [DW-1:0] REQ_A;
    logic [DW-1:0] REQ_B;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_Y;
    logic          RSP_ERROR;
    logic          RSP_TIMEOUT;

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_Y, RSP_ERROR, RSP_TIMEOUT
    );

    modport master (
        output REQ_VALID, REQ_A, REQ_B, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_Y, RSP_ERROR, RSP_TIMEOUT
    );
endinterface

// File: rtl/gcd_driver.sv
// Initiator for one gcd core: takes operand pairs on the request port, pulses
// START into the core, waits for DONE under a timeout and returns the result
// on the response port. All outputs are registered.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready for a request; zero operands short-circuit to S_RESP
//   S_ISSUE | START pulse to the core, timer cleared
//   S_WAIT  | counting cycles until DONE or timer reaches TIMEOUT-1
//   S_RESP  | response valid and frozen until RSP_READY
module gcd_driver #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNTW    = 16
) (
    input  logic            CLK,
    input  logic            RST,
    gcd_driver_if.slave     bus,
    output logic [DW-1:0]   GCD_A,
    output logic [DW-1:0]   GCD_B,
    output logic            GCD_START,
    input  logic [DW-1:0]   GCD_Y,
    input  logic            GCD_DONE,
    input  logic            GCD_ERROR,
    output logic            BUSY,
    output logic [CNTW-1:0] OP_COUNT
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   gcd_a_q, gcd_a_d;
    logic [DW-1:0]   gcd_b_q, gcd_b_d;
    logic [DW-1:0]   rsp_y_q, rsp_y_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            start_q;
    logic            busy_q;

    logic            req_fire;
    logic            req_zero;

    assign req_fire = bus.REQ_VALID && req_ready_q;
    assign req_zero = (bus.REQ_A == '0) || (bus.REQ_B == '0);

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gcd_a_d    = gcd_a_q;
        gcd_b_d    = gcd_b_q;
        rsp_y_d    = rsp_y_q;
        rsp_err_d  = rsp_err_q;
        rsp_to_d   = rsp_to_q;
        op_count_d = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (req_zero) begin
                        // Zero operand never reaches the core.
                        rsp_y_d   = '0;
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b0;
                        state_d   = S_RESP;
                    end else begin
                        gcd_a_d = bus.REQ_A;
                        gcd_b_d = bus.REQ_B;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // DONE takes priority over a simultaneous timer expiry.
                if (GCD_DONE) begin
                    rsp_y_d   = GCD_ERROR ? '0 : GCD_Y;
                    rsp_err_d = GCD_ERROR;
                    rsp_to_d  = 1'b0;
                    state_d   = S_RESP;
                end else if (timer_q == TIMER_TC) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b0;
                    rsp_to_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.RSP_READY) begin
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; flags are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            op_count_q  <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            op_count_q  <= op_count_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            start_q     <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.REQ_READY   = req_ready_q;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_Y       = rsp_y_q;
    assign bus.RSP_ERROR   = rsp_err_q;
    assign bus.RSP_TIMEOUT = rsp_to_q;
    assign GCD_A           = gcd_a_q;
    assign GCD_B           = gcd_b_q;
    assign GCD_START       = start_q;
    assign BUSY            = busy_q;
    assign OP_COUNT        = op_count_q;
endmodule
